any1_decode_queue: RTL and testbench
====================================

Name: any1_decode_queue

Overview:
- Sits directly downstream of the instruction decoder. Accepts one sDecode record per cycle and buffers it in a small FIFO for the register-fetch/issue stage.
- Folds EXI0/EXI1/EXI2 extended-immediate prefixes into the immediate of the next non-prefix instruction. Prefixes never occupy a queue slot.
- Decouples decode from issue stalls and drops everything on a pipeline flush.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- AW, $clog2(DEPTH), pointer width.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard all queued entries and pending prefix state.
- dec_v_i  in  1  dec_i is valid.
- dec_i  in  sDecode  decoded instruction from any1_decode.
- dec_rdy_o  out  1  queue can accept dec_i this cycle.
- q_v_o  out  1  q_o is valid.
- q_o  out  sDecode  head entry.
- q_rdy_i  in  1  consumer takes q_o this cycle.
- count_o  out  AW+1  number of occupied entries.
- pfx_pend_o  out  1  one or more prefixes are held.

Behaviour:
- Reset (async, rst_ni low): read/write pointers 0, count_o=0, q_v_o=0, q_o all-zero, dec_rdy_o=1, pfx_pend_o=0, prefix registers cleared.
- Handshake:
  - accept = dec_v_i & dec_rdy_o.
  - pop = q_v_o & q_rdy_i.
  - dec_rdy_o = (count_o != DEPTH). It has no combinational dependence on q_rdy_i, so a full queue accepts nothing, even in a cycle with a pop.
- Prefix detection: dec_i.ir.r2.opcode in {EXI0, EXI1, EXI2}.
  - An accepted prefix is not enqueued.
  - Its payload ir[31:8] (24b) goes into pfx0/pfx1/pfx2 with the matching valid bit set.
  - The ip of the first prefix in a run goes into pfx_ip.
  - A repeated prefix of the same kind overwrites the earlier one.
- Prefix state machine:
  - IDLE -> PFX on an accepted prefix.
  - PFX -> PFX on further prefixes.
  - PFX -> IDLE on an accepted non-prefix, on flush_i, or on reset.
- Fusion, on an accepted non-prefix in PFX:
  - imm.val[11:0] = dec_i.imm.val[11:0].
  - If pfx0 valid: imm[63:12] = sext52(pfx0).
  - If pfx1 valid: imm[63:36] = sext28(pfx1), overriding.
  - If pfx2 valid: imm[63:60] = pfx2[3:0].
  - ip = pfx_ip, so an exception restarts at the prefix.
  - All other fields pass unchanged. Prefixes preceding an instruction without an immediate are applied anyway, since the consumer ignores imm.
- Enqueue: a non-prefix accept writes mem[wptr] and increments wptr, wrapping mod DEPTH.
- Pop: increments rptr. Simultaneous push and pop leaves count unchanged.
- Output: q_o = mem[rptr]; q_v_o = (count != 0).
- Latency: minimum 1 cycle from accept to q_v_o.
- Flush:
  - Synchronous. In the next cycle count=0, q_v_o=0, pointers equal, and the prefix state is IDLE.
  - dec_i presented in the flush cycle is dropped, even if dec_rdy_o=1.
  - A pop in the flush cycle is still counted as taken by the consumer.
- Empty: q_v_o=0, and q_o holds its last value (don't-care).
- Full: dec_rdy_o=0 and the decoder holds.

Optional Feature:
ANY1_DQ_BYPASS_EN
- With the macro defined: when the queue is empty and q_rdy_i=1, an accepted non-prefix (fused if in PFX) is routed combinationally to q_o with q_v_o=1 in the same cycle and is not written. Latency is 0.
- Without it: latency is always at least 1 cycle.

Decomposition:
- Add to any1_pkg:
  - `typedef enum {DQ_IDLE, DQ_PFX} eDqState`.
  - A `function fnIsPrefix(opcode)` helper.
  - A `function fnFuseImm(...)`.
- Reuse the existing sDecode and EXIx opcode constants.
- One natural sub-module: any1_dq_fifo (generic DEPTH x sDecode storage with pointers and count); the prefix/fusion logic stays in the top.

Test Plan:
1. Fill and drain: push 4 ADDI with q_rdy_i=0 -> count_o=4, dec_rdy_o=0. A fifth push with dec_v_i=1 is not accepted. Then q_rdy_i=1 -> the 4 ADDI emerge in order, one per cycle, then q_v_o=0.
2. Fusion: EXI0 payload 24'h123456 at ip 0x1000, then ADDI imm 12'h789 at 0x1004 -> one entry with imm.val=64'h0000_0001_2345_6789, ip=0x1000, count_o=1.
3. Sign/override: EXI0 24'hFFFFFF, EXI1 24'h000001, then ORI imm 0 -> imm.val=64'h0000_001F_FFFF_F000. pfx_pend_o is 1 between the prefixes and 0 after the ORI.
4. Simultaneous push/pop at count 2 -> count stays 2 and ordering is preserved. Wrap test: 10 sequential pushes/pops -> no loss or duplication.
5. Flush: 3 entries queued plus a pending EXI0; flush_i with dec_v_i=1 -> next cycle count_o=0, q_v_o=0, pfx_pend_o=0. The following ADDI gets an unmodified imm.
6. Async reset mid-stream: rst_ni low for 1 ns between edges -> outputs reset immediately. Under ANY1_DQ_BYPASS_EN: empty queue with q_rdy_i=1 gives q_v_o in the same cycle as the push.

Source files
------------

// File: rtl/any1_decode_queue_pkg.sv
// Shared types and helpers for the decode queue.
// Contents: opcode constants (incl. EXI0/EXI1/EXI2 prefixes), the sDecode record,
// the prefix state enum, the prefix test and the immediate fusion function.
package any1_decode_queue_pkg;

  localparam int unsigned IP_W  = 32;
  localparam int unsigned IR_W  = 32;
  localparam int unsigned IMM_W = 64;
  localparam int unsigned PFX_W = 24;

  localparam logic [7:0] OP_ADDI = 8'h04;
  localparam logic [7:0] OP_ORI  = 8'h09;
  localparam logic [7:0] OP_EXI0 = 8'h50;
  localparam logic [7:0] OP_EXI1 = 8'h51;
  localparam logic [7:0] OP_EXI2 = 8'h52;

  typedef struct packed {
    logic [PFX_W-1:0] payload;
    logic [7:0]       opcode;
  } sR2Inst;

  typedef union packed {
    logic [IR_W-1:0] raw;
    sR2Inst          r2;
  } uInstruction;

  typedef struct packed {
    logic [IMM_W-1:0] val;
  } sImm;

  typedef struct packed {
    logic [IP_W-1:0] ip;
    uInstruction     ir;
    sImm             imm;
    logic [5:0]      rd;
    logic            rfwr;
  } sDecode;

  typedef enum logic {
    DQ_IDLE = 1'b0,
    DQ_PFX  = 1'b1
  } eDqState;

  // True for the extended-immediate prefix opcodes.
  function automatic logic fnIsPrefix(input logic [7:0] opcode);
    return (opcode == OP_EXI0) || (opcode == OP_EXI1) || (opcode == OP_EXI2);
  endfunction

  // Splice held prefix payloads into the upper immediate bits; later prefixes win.
  function automatic logic [IMM_W-1:0] fnFuseImm(
    input logic [IMM_W-1:0] imm,
    input logic [PFX_W-1:0] p0,
    input logic             v0,
    input logic [PFX_W-1:0] p1,
    input logic             v1,
    input logic [3:0]       p2,
    input logic             v2
  );
    logic [IMM_W-1:0] r;
    r = imm;
    if (v0) r[63:12] = {{28{p0[PFX_W-1]}}, p0};
    if (v1) r[63:36] = {{4{p1[PFX_W-1]}}, p1};
    if (v2) r[63:60] = p2;
    return r;
  endfunction

endpackage

// File: rtl/any1_decode_queue_if.sv
// Decoder-side and issue-side handshake bundle of the decode queue.
// slave : the queue (takes dec_*, drives q_*, count_o, pfx_pend_o).
// master: the surrounding pipeline / environment.
interface any1_decode_queue_if
  import any1_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic        dec_v_i;
  sDecode      dec_i;
  logic        dec_rdy_o;
  logic        q_v_o;
  sDecode      q_o;
  logic        q_rdy_i;
  logic [AW:0] count_o;
  logic        pfx_pend_o;

  modport slave (
    input  dec_v_i, dec_i, q_rdy_i,
    output dec_rdy_o, q_v_o, q_o, count_o, pfx_pend_o
  );

  modport master (
    output dec_v_i, dec_i, q_rdy_i,
    input  dec_rdy_o, q_v_o, q_o, count_o, pfx_pend_o
  );
endinterface

// File: rtl/any1_dq_fifo.sv
// DEPTH x sDecode storage with read/write pointers and occupancy count.
// Ports: clk_i, rst_ni (async, active-low), flush (sync clear), push/wdata,
//        pop, rdata (entry at read pointer), count.
// Caller guarantees no push when full and no pop when empty.
module any1_dq_fifo
  import any1_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush,
  input  logic                       push,
  input  sDecode                     wdata,
  input  logic                       pop,
  output sDecode                     rdata,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  sDecode        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Storage, pointers and count; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/any1_decode_queue.sv
// Decode queue: buffers decoded instructions for issue and folds EXI0/1/2
// extended-immediate prefixes into the next non-prefix instruction.
// Ports: clk_i, rst_ni (async, active-low), flush_i (sync drop of everything),
//        dq (any1_decode_queue_if.slave: dec_v_i/dec_i/dec_rdy_o in,
//        q_v_o/q_o/q_rdy_i out, count_o, pfx_pend_o).
// Optional: define ANY1_DQ_BYPASS_EN for a zero-latency path when the queue is
// empty and the consumer is ready.
module any1_decode_queue
  import any1_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  any1_decode_queue_if.slave dq
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  eDqState          state;
  eDqState          state_nxt;
  logic [PFX_W-1:0] pfx0;
  logic [PFX_W-1:0] pfx1;
  logic [3:0]       pfx2;   // only the low nibble of EXI2 reaches the immediate
  logic             pfx0_v;
  logic             pfx1_v;
  logic             pfx2_v;
  logic [IP_W-1:0]  pfx_ip;

  logic             rdy;
  logic             is_pfx;
  logic             take;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             empty;
  sDecode           fused;
  sDecode           head;
  logic [AW:0]      count;

  // Prefix state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= DQ_IDLE;
    else         state <= state_nxt;
  end

  // Next state, handshake qualification and fusion of the incoming record.
  always_comb begin
    state_nxt = state;
    rdy       = (count != FULL_CNT);
    empty     = (count == '0);
    is_pfx    = fnIsPrefix(dq.dec_i.ir.r2.opcode);
    // A flush drops the incoming record even though it was handshaked.
    take      = dq.dec_v_i & rdy & ~flush_i;
    fused     = dq.dec_i;
    bypass    = 1'b0;

    if (state == DQ_PFX) begin
      fused.imm.val = fnFuseImm(dq.dec_i.imm.val, pfx0, pfx0_v, pfx1, pfx1_v,
                                pfx2, pfx2_v);
      // Restart point for exceptions is the first prefix of the run.
      fused.ip      = pfx_ip;
    end

`ifdef ANY1_DQ_BYPASS_EN
    bypass = take & ~is_pfx & empty & dq.q_rdy_i;
`endif

    push = take & ~is_pfx & ~bypass;
    pop  = dq.q_rdy_i & ~empty;

    case (state)
      DQ_IDLE: if (take & is_pfx)  state_nxt = DQ_PFX;
      DQ_PFX:  if (take & ~is_pfx) state_nxt = DQ_IDLE;
      default: state_nxt = DQ_IDLE;
    endcase
    if (flush_i) state_nxt = DQ_IDLE;
  end

  // Held prefix payloads; a repeat of the same kind overwrites the earlier one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pfx0   <= '0;
      pfx1   <= '0;
      pfx2   <= '0;
      pfx0_v <= 1'b0;
      pfx1_v <= 1'b0;
      pfx2_v <= 1'b0;
      pfx_ip <= '0;
    end else if (flush_i || (take && !is_pfx)) begin
      pfx0_v <= 1'b0;
      pfx1_v <= 1'b0;
      pfx2_v <= 1'b0;
    end else if (take && is_pfx) begin
      if (state == DQ_IDLE) pfx_ip <= dq.dec_i.ip;
      if (dq.dec_i.ir.r2.opcode == OP_EXI0) begin
        pfx0   <= dq.dec_i.ir.r2.payload;
        pfx0_v <= 1'b1;
      end else if (dq.dec_i.ir.r2.opcode == OP_EXI1) begin
        pfx1   <= dq.dec_i.ir.r2.payload;
        pfx1_v <= 1'b1;
      end else begin
        pfx2   <= dq.dec_i.ir.r2.payload[3:0];
        pfx2_v <= 1'b1;
      end
    end
  end

  any1_dq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (flush_i),
    .push   (push),
    .wdata  (fused),
    .pop    (pop),
    .rdata  (head),
    .count  (count)
  );

  assign dq.dec_rdy_o  = rdy;
  assign dq.count_o    = count;
  assign dq.pfx_pend_o = (state == DQ_PFX);
  // The bypass path forwards the incoming record while the queue is empty.
  assign dq.q_v_o      = ~empty | bypass;
  assign dq.q_o        = bypass ? fused : head;

endmodule

// File: tb/tb_any1_decode_queue.sv
// Directed, table-driven bench for any1_decode_queue (DEPTH = 4).
module tb_any1_decode_queue;
  import any1_decode_queue_pkg::*;

  typedef struct {
    logic        dv;
    logic [7:0]  op;
    logic [23:0] pay;
    logic [31:0] ip;
    logic [63:0] imm;
    logic        qr;
    logic        fl;
    logic [2:0]  e_cnt;
    logic        e_qv;
    logic        e_rdy;
    logic        e_pend;
    logic [31:0] e_ip;
    logic [63:0] e_imm;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;
  vec_t tbl[$];

  any1_decode_queue_if #(.DEPTH(4)) dq ();

  any1_decode_queue #(.DEPTH(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .dq      (dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sDecode mkdec(input logic [31:0] ip, input logic [7:0] op,
                                   input logic [23:0] pay, input logic [63:0] imm);
    sDecode d;
    d = '0;
    d.ip            = ip;
    d.ir.r2.opcode  = op;
    d.ir.r2.payload = pay;
    d.imm.val       = imm;
    d.rd            = 6'd3;
    d.rfwr          = 1'b1;
    return d;
  endfunction

  function automatic vec_t mkv(input logic dv, input logic [7:0] op, input logic [23:0] pay,
                               input logic [31:0] ip, input logic [63:0] imm,
                               input logic qr, input logic fl, input logic [2:0] e_cnt,
                               input logic e_qv, input logic e_rdy, input logic e_pend,
                               input logic [31:0] e_ip, input logic [63:0] e_imm);
    vec_t v;
    v.dv = dv; v.op = op; v.pay = pay; v.ip = ip; v.imm = imm; v.qr = qr; v.fl = fl;
    v.e_cnt = e_cnt; v.e_qv = e_qv; v.e_rdy = e_rdy; v.e_pend = e_pend;
    v.e_ip = e_ip; v.e_imm = e_imm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    dq.dec_v_i = 1'b0;
    dq.dec_i   = '0;
    dq.q_rdy_i = 1'b0;
    flush      = 1'b0;
  endtask

  // Drive one vector between edges, then check the state after the next edge.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    dq.dec_v_i = v.dv;
    dq.dec_i   = mkdec(v.ip, v.op, v.pay, v.imm);
    dq.q_rdy_i = v.qr;
    flush      = v.fl;
    @(posedge clk);
    #1;
    chk({name, ".count"}, 160'(dq.count_o), 160'(v.e_cnt));
    chk({name, ".q_v"}, 160'(dq.q_v_o), 160'(v.e_qv));
    chk({name, ".rdy"}, 160'(dq.dec_rdy_o), 160'(v.e_rdy));
    chk({name, ".pend"}, 160'(dq.pfx_pend_o), 160'(v.e_pend));
    if (v.e_qv) begin
      chk({name, ".ip"}, 160'(dq.q_o.ip), 160'(v.e_ip));
      chk({name, ".imm"}, 160'(dq.q_o.imm.val), 160'(v.e_imm));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle();

    // Fill/drain: fifth push blocked even while a pop happens on the full queue.
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h100, 64'h1, 0, 0, 3'd1, 1, 1, 0, 32'h100, 64'h1));
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h104, 64'h2, 0, 0, 3'd2, 1, 1, 0, 32'h100, 64'h1));
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h108, 64'h3, 0, 0, 3'd3, 1, 1, 0, 32'h100, 64'h1));
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h10C, 64'h4, 0, 0, 3'd4, 1, 0, 0, 32'h100, 64'h1));
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h110, 64'h5, 1, 0, 3'd3, 1, 1, 0, 32'h104, 64'h2));
    tbl.push_back(mkv(0, OP_ADDI, 0, 32'h0,   64'h0, 1, 0, 3'd2, 1, 1, 0, 32'h108, 64'h3));
    tbl.push_back(mkv(0, OP_ADDI, 0, 32'h0,   64'h0, 1, 0, 3'd1, 1, 1, 0, 32'h10C, 64'h4));
    tbl.push_back(mkv(0, OP_ADDI, 0, 32'h0,   64'h0, 1, 0, 3'd0, 0, 1, 0, 32'h0, 64'h0));
    // Fusion of a single EXI0.
    tbl.push_back(mkv(1, OP_EXI0, 24'h123456, 32'h1000, 64'h0, 0, 0, 3'd0, 0, 1, 1, 32'h0, 64'h0));
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h1004, 64'h789, 0, 0, 3'd1, 1, 1, 0,
                      32'h1000, 64'h0000_0001_2345_6789));
    tbl.push_back(mkv(0, OP_ADDI, 0, 32'h0, 64'h0, 1, 0, 3'd0, 0, 1, 0, 32'h0, 64'h0));
    // Sign extension of EXI0 overridden by EXI1.
    tbl.push_back(mkv(1, OP_EXI0, 24'hFFFFFF, 32'h2000, 64'h0, 0, 0, 3'd0, 0, 1, 1, 32'h0, 64'h0));
    tbl.push_back(mkv(1, OP_EXI1, 24'h000001, 32'h2004, 64'h0, 0, 0, 3'd0, 0, 1, 1, 32'h0, 64'h0));
    tbl.push_back(mkv(1, OP_ORI, 0, 32'h2008, 64'h0, 0, 0, 3'd1, 1, 1, 0,
                      32'h2000, 64'h0000_001F_FFFF_F000));
    tbl.push_back(mkv(0, OP_ADDI, 0, 32'h0, 64'h0, 1, 0, 3'd0, 0, 1, 0, 32'h0, 64'h0));
    // Repeated EXI0 overwrites; EXI2 sets the top nibble; entry stays queued.
    tbl.push_back(mkv(1, OP_EXI0, 24'h000001, 32'h3000, 64'h0, 0, 0, 3'd0, 0, 1, 1, 32'h0, 64'h0));
    tbl.push_back(mkv(1, OP_EXI0, 24'h000002, 32'h3004, 64'h0, 0, 0, 3'd0, 0, 1, 1, 32'h0, 64'h0));
    tbl.push_back(mkv(1, OP_EXI2, 24'h00000A, 32'h3008, 64'h0, 0, 0, 3'd0, 0, 1, 1, 32'h0, 64'h0));
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h300C, 64'h0AB, 0, 0, 3'd1, 1, 1, 0,
                      32'h3000, 64'hA000_0000_0000_20AB));
    // Simultaneous push/pop at count 2.
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h4000, 64'h10, 0, 0, 3'd2, 1, 1, 0,
                      32'h3000, 64'hA000_0000_0000_20AB));
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h4004, 64'h11, 1, 0, 3'd2, 1, 1, 0, 32'h4000, 64'h10));
    tbl.push_back(mkv(1, OP_ADDI, 0, 32'h4008, 64'h12, 1, 0, 3'd2, 1, 1, 0, 32'h4004, 64'h11));
    tbl.push_back(mkv(0, OP_ADDI, 0, 32'h0, 64'h0, 1, 0, 3'd1, 1, 1, 0, 32'h4008, 64'h12));
    tbl.push_back(mkv(0, OP_ADDI, 0, 32'h0, 64'h0, 1, 0, 3'd0, 0, 1, 0, 32'h0, 64'h0));

    #12;
    chk("reset.count", 160'(dq.count_o), 160'(0));
    chk("reset.q_v", 160'(dq.q_v_o), 160'(0));
    chk("reset.rdy", 160'(dq.dec_rdy_o), 160'(1));
    chk("reset.pend", 160'(dq.pfx_pend_o), 160'(0));
    chk("reset.q", 160'(dq.q_o), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Wrap: ten back-to-back pushes with pops, head always the latest entry.
    for (int i = 0; i < 10; i++) begin
      apply(mkv(1, OP_ADDI, 0, 32'h5000 + 32'(4 * i), 64'(i), (i != 0), 0, 3'd1, 1, 1, 0,
                32'h5000 + 32'(4 * i), 64'(i)), $sformatf("wrap%0d", i));
    end
    apply(mkv(0, OP_ADDI, 0, 32'h0, 64'h0, 1, 0, 3'd0, 0, 1, 0, 32'h0, 64'h0), "wrap_end");

    // Flush with three entries and a pending prefix; flush-cycle push dropped.
    apply(mkv(1, OP_ADDI, 0, 32'h6000, 64'h1, 0, 0, 3'd1, 1, 1, 0, 32'h6000, 64'h1), "fl0");
    apply(mkv(1, OP_ADDI, 0, 32'h6004, 64'h2, 0, 0, 3'd2, 1, 1, 0, 32'h6000, 64'h1), "fl1");
    apply(mkv(1, OP_ADDI, 0, 32'h6008, 64'h3, 0, 0, 3'd3, 1, 1, 0, 32'h6000, 64'h1), "fl2");
    apply(mkv(1, OP_EXI0, 24'h000077, 32'h600C, 64'h0, 0, 0, 3'd3, 1, 1, 1, 32'h6000, 64'h1), "fl3");
    apply(mkv(1, OP_ADDI, 0, 32'h6010, 64'h5, 1, 1, 3'd0, 0, 1, 0, 32'h0, 64'h0), "flush");
    apply(mkv(1, OP_ADDI, 0, 32'h6014, 64'h21, 0, 0, 3'd1, 1, 1, 0, 32'h6014, 64'h21), "post_fl");
    apply(mkv(0, OP_ADDI, 0, 32'h0, 64'h0, 1, 0, 3'd0, 0, 1, 0, 32'h0, 64'h0), "post_fl_pop");

    // Asynchronous reset between edges with an entry and a prefix held.
    apply(mkv(1, OP_ADDI, 0, 32'h7000, 64'h7, 0, 0, 3'd1, 1, 1, 0, 32'h7000, 64'h7), "ar0");
    apply(mkv(1, OP_EXI1, 24'h000005, 32'h7004, 64'h0, 0, 0, 3'd1, 1, 1, 1, 32'h7000, 64'h7), "ar1");
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.count", 160'(dq.count_o), 160'(0));
    chk("areset.q_v", 160'(dq.q_v_o), 160'(0));
    chk("areset.rdy", 160'(dq.dec_rdy_o), 160'(1));
    chk("areset.pend", 160'(dq.pfx_pend_o), 160'(0));
    chk("areset.q", 160'(dq.q_o), 160'(0));
    rst_n = 1'b1;
    apply(mkv(1, OP_ADDI, 0, 32'h7008, 64'h33, 0, 0, 3'd1, 1, 1, 0, 32'h7008, 64'h33), "ar_after");
    apply(mkv(0, OP_ADDI, 0, 32'h0, 64'h0, 1, 0, 3'd0, 0, 1, 0, 32'h0, 64'h0), "ar_pop");

`ifdef ANY1_DQ_BYPASS_EN
    // Zero-latency path: empty queue, consumer ready.
    @(negedge clk);
    dq.dec_v_i = 1'b1;
    dq.dec_i   = mkdec(32'h8000, OP_ADDI, 24'h0, 64'h44);
    dq.q_rdy_i = 1'b1;
    #1;
    chk("bypass.q_v", 160'(dq.q_v_o), 160'(1));
    chk("bypass.ip", 160'(dq.q_o.ip), 160'(32'h8000));
    chk("bypass.imm", 160'(dq.q_o.imm.val), 160'(64'h44));
    @(posedge clk);
    #1;
    chk("bypass.count", 160'(dq.count_o), 160'(0));
`endif

    @(negedge clk);
    drive_idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
